// File: rtl/ifu_fetch_queue.sv
// Instruction fetch front end: sequential PC generation, credit-limited imem requests,
// in-order {inst, pc} queue toward decode. Optional address-fault entries: IFU_FETCH_ADEF_EN.
`ifndef LA64_INST_WIDTH
`define LA64_INST_WIDTH 32
`endif

module ifu_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    output logic                        imem_req_valid,
    input  logic                        imem_req_ready,
    output logic [31:0]                 imem_req_addr,
    input  logic                        imem_resp_valid,
    input  logic [`LA64_INST_WIDTH-1:0] imem_resp_inst,
    input  logic                        redirect_valid,
    input  logic [31:0]                 redirect_pc,
    output logic                        dec_valid,
    input  logic                        dec_ready,
    output logic [`LA64_INST_WIDTH-1:0] dec_inst,
    output logic [31:0]                 dec_pc,
    output logic                        dec_adef
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned IW = `LA64_INST_WIDTH;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1
`ifdef IFU_FETCH_ADEF_EN
        , ST_HALT = 2'd2
`endif
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   live;
    logic [AW-1:0]   tag_wr_q, tag_rd_q, wr_ptr_q, rd_ptr_q;

    logic [31:0]     tag_mem  [DEPTH];
    logic [IW-1:0]   inst_mem [DEPTH];
    logic [31:0]     pc_mem   [DEPTH];

    logic [31:0]     redir_pc;
    logic            req_fire, resp_drop, resp_keep, adef_push, push, pop;
    logic [IW-1:0]   push_inst;
    logic [31:0]     push_pc;

`ifdef IFU_FETCH_ADEF_EN
    logic            redir_misal;
    logic            adef_pend_q;
    logic            push_adef;
    logic            adef_mem [DEPTH];

    assign redir_pc    = redirect_pc;
    assign redir_misal = |redirect_pc[1:0];
    assign adef_push   = adef_pend_q & ~redirect_valid;
`else
    assign redir_pc    = redirect_pc & 32'hFFFF_FFFC;
    assign adef_push   = 1'b0;
`endif

    // Requests already doomed by a redirect do not hold a queue credit.
    assign live           = inflight_q - drop_q;
    assign imem_req_valid = (state_q == ST_RUN) && !redirect_valid &&
                            ((32'(count_q) + 32'(live)) < DEPTH);
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid & imem_req_ready;

    assign resp_drop  = (drop_q != '0);
    assign resp_keep  = imem_resp_valid & ~resp_drop & ~redirect_valid;
    assign push       = resp_keep | adef_push;
    assign pop        = dec_valid & dec_ready;
    assign inflight_d = inflight_q + CW'(req_fire) - CW'(imem_resp_valid);
    assign count_d    = redirect_valid ? '0 : (count_q + CW'(push) - CW'(pop));

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            default: ;
        endcase
        if (req_fire) pc_d = pc_q + 32'd4;
        if (imem_resp_valid && resp_drop) drop_d = drop_q - 1'b1;
        if (redirect_valid) begin
            pc_d    = redir_pc;
            drop_d  = inflight_d;
            state_d = ST_RUN;
`ifdef IFU_FETCH_ADEF_EN
            if (redir_misal) state_d = ST_HALT;
`endif
        end
    end

    always_comb begin
        push_inst = imem_resp_inst;
        push_pc   = tag_mem[tag_rd_q];
`ifdef IFU_FETCH_ADEF_EN
        push_adef = 1'b0;
        if (adef_push) begin
            push_inst = '0;
            push_pc   = pc_q;
            push_adef = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            count_q    <= '0;
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            if (redirect_valid) begin
                tag_wr_q <= '0;
                tag_rd_q <= '0;
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (req_fire)  tag_wr_q <= tag_wr_q + 1'b1;
                if (resp_keep) tag_rd_q <= tag_rd_q + 1'b1;
                if (push)      wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)       rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

`ifdef IFU_FETCH_ADEF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) adef_pend_q <= 1'b0;
        else        adef_pend_q <= redirect_valid & redir_misal;
    end
`endif

    always_ff @(posedge clk) begin
        if (req_fire) tag_mem[tag_wr_q] <= pc_q;
        if (push) begin
            inst_mem[wr_ptr_q] <= push_inst;
            pc_mem[wr_ptr_q]   <= push_pc;
`ifdef IFU_FETCH_ADEF_EN
            adef_mem[wr_ptr_q] <= push_adef;
`endif
        end
    end

    assign dec_valid = (count_q != '0);
    assign dec_inst  = dec_valid ? inst_mem[rd_ptr_q] : '0;
    assign dec_pc    = dec_valid ? pc_mem[rd_ptr_q] : '0;
`ifdef IFU_FETCH_ADEF_EN
    assign dec_adef  = dec_valid ? adef_mem[rd_ptr_q] : 1'b0;
`else
    assign dec_adef  = 1'b0;
`endif

`ifndef SYNTHESIS
    a_no_overrun: assert property (@(posedge clk) disable iff (!rst_n)
        push |-> (count_q < CW'(DEPTH)));
    a_no_inflight_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        imem_resp_valid |-> (inflight_q != '0));
    a_drop_bounded: assert property (@(posedge clk) disable iff (!rst_n)
        drop_q <= inflight_q);
`endif

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Scoreboard bench for ifu_fetch_queue: behavioural imem with variable latency,
// expected {pc, inst, adef} queued on request accept and checked on each decode handshake.
`ifndef LA64_INST_WIDTH
`define LA64_INST_WIDTH 32
`endif

module tb_ifu_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h1c00_0000;
    localparam int          IW       = `LA64_INST_WIDTH;

    logic          clk;
    logic          rst_n;
    logic          imem_req_valid;
    logic          imem_req_ready;
    logic [31:0]   imem_req_addr;
    logic          imem_resp_valid;
    logic [IW-1:0] imem_resp_inst;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          dec_valid;
    logic          dec_ready;
    logic [IW-1:0] dec_inst;
    logic [31:0]   dec_pc;
    logic          dec_adef;

    ifu_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_inst  (imem_resp_inst),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .dec_valid       (dec_valid),
        .dec_ready       (dec_ready),
        .dec_inst        (dec_inst),
        .dec_pc          (dec_pc),
        .dec_adef        (dec_adef)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adef;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    exp_t        exp_q[$];
    mreq_t       mem_q[$];
    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          lat = 1;
    int          req_cnt = 0;
    int          since_redir = 99;
    logic [31:0] exp_addr = RESET_PC;
    logic [31:0] last_addr = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5a5a_0f0f;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_dec(input int max);
        int n;
        n = 0;
        while (!dec_valid && n < max) begin
            tick(1);
            n++;
        end
        chk("wait_dec", 32'(dec_valid), 32'd1);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // In-order memory: each accepted request answers once its due cycle arrives.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            mem_q.delete();
            imem_resp_valid = 1'b0;
        end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_inst  = IW'(inst_of(mem_q[0].addr));
            void'(mem_q.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
            exp_addr    = RESET_PC;
            since_redir = 99;
        end else begin
            if (since_redir < 99) since_redir++;
            if (since_redir == 1 || since_redir == 2)
                chk("redir_dec_low", 32'(dec_valid), 32'd0);
            if (imem_req_valid) begin
                chk("req_addr", imem_req_addr, exp_addr);
                if (imem_req_ready) begin
                    mem_q.push_back('{addr: imem_req_addr, due: cyc + lat});
                    exp_q.push_back('{pc: exp_addr, inst: inst_of(exp_addr), adef: 1'b0});
                    last_addr = imem_req_addr;
                    exp_addr  = exp_addr + 32'd4;
                    req_cnt++;
                end
            end
            if (dec_valid && dec_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_empty", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("dec_pc", dec_pc, e.pc);
                    chk("dec_inst", 32'(dec_inst), e.inst);
                    chk("dec_adef", 32'(dec_adef), 32'(e.adef));
                end
            end
            if (redirect_valid) begin
                exp_q.delete();
`ifdef IFU_FETCH_ADEF_EN
                if (redirect_pc[1:0] != 2'b00) begin
                    exp_q.push_back('{pc: redirect_pc, inst: 32'd0, adef: 1'b1});
                    exp_addr = redirect_pc;
                end else begin
                    exp_addr    = redirect_pc;
                    since_redir = 0;
                end
`else
                exp_addr    = {redirect_pc[31:2], 2'b00};
                since_redir = 0;
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time got %0t expected finish", $time);
        $fatal(1);
    end

    initial begin
        int base;
        int n;
        rst_n          = 1'b0;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        dec_ready      = 1'b1;
        tick(3);

        // Reset values
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_req_addr", imem_req_addr, RESET_PC);
        chk("rst_dec_valid", 32'(dec_valid), 32'd0);
        chk("rst_dec_inst", 32'(dec_inst), 32'd0);
        chk("rst_dec_pc", dec_pc, 32'd0);
        chk("rst_dec_adef", 32'(dec_adef), 32'd0);

        // Boot cycle, then streaming with a 1-cycle memory
        rst_n = 1'b1;
        chk("boot_noreq", 32'(imem_req_valid), 32'd0);
        tick(1);
        chk("first_req", 32'(imem_req_valid), 32'd1);
        chk("first_addr", imem_req_addr, RESET_PC);
        chk("lat_dec_c1", 32'(dec_valid), 32'd0);
        tick(1);
        chk("lat_dec_c2", 32'(dec_valid), 32'd0);
        tick(1);
        chk("first_dec_valid", 32'(dec_valid), 32'd1);
        chk("first_dec_pc", dec_pc, RESET_PC);
        for (int i = 0; i < 8; i++) begin
            tick(1);
            chk("stream_valid", 32'(dec_valid), 32'd1);
        end

        // Decode stalled: credits allow exactly DEPTH requests
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1c00_0040;
        dec_ready      = 1'b0;
        tick(1);
        redirect_valid = 1'b0;
        base = req_cnt;
        tick(20);
        chk("full_reqs", 32'(req_cnt - base), 32'(DEPTH));
        chk("full_stall", 32'(imem_req_valid), 32'd0);
        chk("full_head_pc", dec_pc, 32'h1c00_0040);
        dec_ready = 1'b1;
        tick(1);
        dec_ready = 1'b0;
        tick(6);
        chk("one_pop_one_req", 32'(req_cnt - base), 32'(DEPTH + 1));
        dec_ready = 1'b1;
        tick(10);

        // Slow memory: 3 outstanding requests discarded by a redirect
        lat            = 5;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1c00_0080;
        tick(1);
        redirect_valid = 1'b0;
        tick(3);
        chk("inflight3", 32'(mem_q.size()), 32'd3);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1c00_0100;
        tick(1);
        redirect_valid = 1'b0;
        wait_dec(30);
        chk("after_drop_pc", dec_pc, 32'h1c00_0100);
        tick(10);

        // Redirect coincident with a response and a decode handshake
        lat = 1;
        tick(15);
        chk("coinc_resp", 32'(imem_resp_valid), 32'd1);
        chk("coinc_hs", 32'(dec_valid & dec_ready), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1c00_0300;
        tick(1);
        redirect_valid = 1'b0;
        chk("flush_empty", 32'(dec_valid), 32'd0);
        wait_dec(10);
        chk("coinc_next_pc", dec_pc, 32'h1c00_0300);
        tick(5);

        // PC wrap at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        tick(1);
        redirect_valid = 1'b0;
        base = req_cnt;
        n = 0;
        while ((req_cnt - base) < 3 && n < 20) begin
            tick(1);
            n++;
        end
        chk("wrap_cnt", 32'(req_cnt - base >= 3), 32'd1);
        chk("wrap_addr", last_addr, 32'h0000_0000);
        tick(8);

`ifdef IFU_FETCH_ADEF_EN
        // Misaligned redirect: one fault entry, no fetch until the next redirect
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1c00_0102;
        tick(1);
        redirect_valid = 1'b0;
        base = req_cnt;
        wait_dec(5);
        chk("adef_flag", 32'(dec_adef), 32'd1);
        chk("adef_pc", dec_pc, 32'h1c00_0102);
        chk("adef_inst", 32'(dec_inst), 32'd0);
        tick(10);
        chk("halt_noreq", 32'(req_cnt - base), 32'd0);
        chk("halt_empty", 32'(dec_valid), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1c00_0200;
        tick(1);
        redirect_valid = 1'b0;
        wait_dec(10);
        chk("resume_pc", dec_pc, 32'h1c00_0200);
        chk("resume_adef", 32'(dec_adef), 32'd0);
        tick(8);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ifu_fetch_queue.md
Name: ifu_fetch_queue

Overview:
- Instruction fetch front end: generates the sequential PC and issues requests to instruction memory.
- Buffers returned instructions with their PCs in an in-order FIFO.
- Presents one {inst, pc} per cycle to the decode stage over a valid/ready handshake.
- Branch/exception redirects flush the queue and discard stale in-flight responses.

Parameters:
- DEPTH, 4, FIFO entries and max outstanding requests; power of two, ≥2
- RESET_PC, 32'h1c00_0000, first fetch address after reset

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  fetch address, word aligned
- imem_resp_valid  in  1  instruction returned, in request order, ≥1 cycle after accept
- imem_resp_inst  in  `LA64_INST_WIDTH  returned instruction word
- redirect_valid  in  1  redirect from branch/exception unit
- redirect_pc  in  32  new fetch PC
- dec_valid  out  1  queue head valid
- dec_ready  in  1  decode consumes head
- dec_inst  out  `LA64_INST_WIDTH  head instruction
- dec_pc  out  32  head PC
- dec_adef  out  1  head carries address-error fault (see Optional Feature)

Behaviour:
- Reset: clk is the only clock; reset is synchronous and active-low on rst_n. When rst_n=0 at a rising edge:
  - state=BOOT, pc=RESET_PC, fifo_count=0, inflight=0, drop_cnt=0.
  - Outputs: imem_req_valid=0, imem_req_addr=RESET_PC, dec_valid=0, dec_inst=0, dec_pc=0, dec_adef=0.
- States:
  - BOOT: one cycle, no request → RUN.
  - RUN: normal fetch.
  - HALT: only with the feature; no requests until redirect.
- Issue rule: imem_req_valid=1 iff state==RUN, !redirect_valid, and fifo_count + (inflight - drop_cnt) < DEPTH.
  - imem_req_valid may drop without acceptance.
  - imem_req_addr=pc.
  - On accept: pc += 4 (32-bit wrap 0xFFFF_FFFC→0x0), inflight += 1.
  - A per-request PC tag FIFO (depth DEPTH) records the PC.
- Response: imem_resp_valid decrements inflight. If drop_cnt>0, the response is discarded and drop_cnt -= 1. Otherwise {inst, popped tag PC} is written to the data FIFO.
- Decode side: dec_* is driven from the FIFO head (registered storage). A response in cycle N gives dec_valid=1 at cycle N+1 at earliest; there is no bypass. A pop happens when dec_valid & dec_ready.
- Simultaneous push and pop: allowed in any state, count unchanged.
  - Full FIFO cannot be overrun: credits guarantee space, and asserting that a push never happens at fifo_count==DEPTH is a checked assertion.
- Redirect (highest priority, same cycle):
  - Data FIFO and tag FIFO flushed to empty.
  - pc=redirect_pc; state=RUN (also from BOOT/HALT).
  - No request issued that cycle.
  - drop_cnt = inflight after this cycle's response decrement; inflight itself is unchanged apart from that decrement.
  - A decode handshake in the same cycle completes; that entry is still consumed.
  - A response in the same cycle is discarded.
  - Back-to-back redirects: latest wins; drop_cnt recomputed each time.
- dec_valid is low for at least 2 cycles after a redirect. With a 1-cycle memory and ready memory: redirect at N, request at N+1, response at N+2, dec_valid at N+3.
- inflight, drop_cnt: width clog2(DEPTH)+1, never underflow (assertion).

Optional Feature:
- Macro: IFU_FETCH_ADEF_EN.
- Defined, redirect with redirect_pc[1:0]!=0:
  - Flush as normal; pc=redirect_pc; state=HALT.
  - The next cycle enqueues one entry {inst=0, pc=redirect_pc, adef=1} with no memory request.
  - Remains in HALT until the next redirect.
  - dec_adef is stored per entry.
- Undefined: redirect_pc[1:0] forced to 0, HALT state absent, dec_adef tied 0.

Test Plan:
- Reset, imem always ready, 1-cycle response, dec_ready=1 → requests 0x1c000000, 0x1c000004, …; first dec_valid 3 cycles after reset deassert, dec_pc increments by 4 each cycle.
- dec_ready=0, DEPTH=4 → exactly 4 requests issued, then imem_req_valid=0. Raise dec_ready → one new request per pop, no loss or duplication.
- Response latency 5 cycles, 3 requests in flight, redirect to 0x1c000100 → next 3 responses dropped, first dec_pc=0x1c000100, no stale PC ever presented.
- Redirect coincident with imem_resp_valid and a dec handshake → handshake entry consumed once, response dropped, FIFO empty next cycle.
- pc=0xFFFFFFF8 via redirect → requests 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- IFU_FETCH_ADEF_EN: redirect to 0x1c000102 → one entry pc=0x1c000102, adef=1, inst=0; no imem requests until a redirect to 0x1c000200 resumes fetch.
